life_seq: RTL

LIFE_SEQ -- requirements
Module: life_seq

---
 rtl/life_pkg.sv | 20 ++
 rtl/life_pos_cnt.sv | 27 ++
 rtl/life_seq.sv | 110 +++++++++++
 3 files changed

// File: rtl/life_pkg.sv
// Shared definitions for the life-array column sequencer.
package life_pkg;

    localparam int COL_LEN_DEF = 64;
    localparam int GEN_W_DEF   = 16;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_STEP = 2'd1,
        OP_RUN  = 2'd2,
        OP_NOP  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2
    } state_e;

endpackage

// File: rtl/life_pos_cnt.sv
// Cell position counter; wrap flags the last position of a column while enabled.
module life_pos_cnt #(
    parameter int LEN = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   clr,
    output logic [$clog2(LEN)-1:0] count,
    output logic                   wrap
);

    localparam int            W    = $clog2(LEN);
    localparam logic [W-1:0]  LAST = W'(LEN - 1);

    // LEN is a power of two, so the natural rollover lands back on zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign wrap = en && (count == LAST);

endmodule

// File: rtl/life_seq.sv
// Sequencer for a column-shifted Game-of-Life array: seeding, single steps and
// multi-generation runs with a boundary-aligned stop.
module life_seq
    import life_pkg::*;
#(
    parameter int COL_LEN = COL_LEN_DEF,
    parameter int GEN_W   = GEN_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [GEN_W-1:0]           cmd_len,
    input  logic                       stop,
    input  logic                       load_valid,
    output logic                       arr_shift,
    output logic                       arr_load,
    output logic [$clog2(COL_LEN)-1:0] arr_pos,
    output logic                       gen_done,
    output logic [GEN_W-1:0]           gen_count,
    output logic                       busy
);

    state_e            state, state_nxt;
    op_e               op;
    logic              accept, pos_en, pos_clr, pos_wrap;
    logic              stop_seen, last_gen;
    logic              shift_run, free_run, stop_lat;
    logic [GEN_W-1:0]  rem;

    life_pos_cnt #(.LEN(COL_LEN)) u_pos (
        .clk   (clk),
        .rst   (rst),
        .en    (pos_en),
        .clr   (pos_clr),
        .count (arr_pos),
        .wrap  (pos_wrap)
    );

    // During LOAD the shift strobe qualifies the external seed stream.
    assign arr_shift = shift_run | (arr_load & load_valid);

    always_comb begin
        state_nxt = state;
        op        = op_e'(cmd_op);
        accept    = cmd_valid && cmd_ready;
        pos_en    = (state == ST_LOAD && load_valid) || (state == ST_COMPUTE);
        pos_clr   = accept;
        stop_seen = stop_lat || stop;
        last_gen  = stop_seen || (!free_run && rem == GEN_W'(1));
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_LOAD:         state_nxt = ST_LOAD;
                        OP_STEP, OP_RUN: state_nxt = ST_COMPUTE;
                        default:         state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD:    if (pos_wrap) state_nxt = ST_IDLE;
            ST_COMPUTE: if (pos_wrap && last_gen) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            arr_load  <= 1'b0;
            shift_run <= 1'b0;
            gen_done  <= 1'b0;
            gen_count <= '0;
            rem       <= '0;
            free_run  <= 1'b0;
            stop_lat  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= (state_nxt == ST_IDLE);
            busy      <= (state_nxt != ST_IDLE);
            arr_load  <= (state_nxt == ST_LOAD);
            shift_run <= (state_nxt == ST_COMPUTE);
            gen_done  <= (state == ST_COMPUTE) && pos_wrap;

            if (accept && op == OP_LOAD) begin
                gen_count <= '0;
            end else if (state == ST_COMPUTE && pos_wrap) begin
                gen_count <= gen_count + GEN_W'(1);
            end

            // Remaining-generation down-counter; a zero length means free-run.
            if (accept && op == OP_STEP) begin
                rem      <= GEN_W'(1);
                free_run <= 1'b0;
            end else if (accept && op == OP_RUN) begin
                rem      <= cmd_len;
                free_run <= (cmd_len == '0);
            end else if (state == ST_COMPUTE && pos_wrap) begin
                rem      <= rem - GEN_W'(1);
            end

            // Stop is held only while a run continues, so it never leaks into the next command.
            stop_lat <= (state == ST_COMPUTE && state_nxt == ST_COMPUTE) ? stop_seen : 1'b0;
        end
    end

endmodule
